muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 154 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: drives a shared multiplier and runs an
// internal restoring divider, then writes back through MEM/WB.
module muldiv_ctrl #(
  parameter int MULT_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd_addr,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        mult_start,
  output logic [1:0]  mult_type,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic [31:0] mult_result,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [31:0] wb_data
);

  typedef enum logic [2:0] {
    IDLE, MUL_WAIT, DIV_RUN, DIV_FIX, DONE
  } state_t;

  state_t state, state_nx;

  logic [5:0]  cnt;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] quo, rem, dvs, res;
  logic        neg_q, neg_r;

  logic        accept, is_div, sgn_in;
  logic        dz, ovf, fast;
  logic [31:0] fast_res, abs_a, abs_b;
  logic [32:0] sh, diff;

  assign accept = (state == IDLE) & req_valid & ~flush;
  assign is_div = req_funct3[2];
  assign sgn_in = ~req_funct3[0];
  assign dz     = (req_rs2 == 32'd0);
  assign ovf    = sgn_in & (req_rs1 == 32'h8000_0000)
                & (req_rs2 == 32'hFFFF_FFFF);
  assign fast   = is_div & (dz | ovf);

  always_comb begin
    fast_res = 32'd0;
    if (dz)
      fast_res = req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
    else if (ovf)
      fast_res = req_funct3[1] ? 32'd0 : 32'h8000_0000;
  end

  assign abs_a = (sgn_in & req_rs1[31]) ? (~req_rs1 + 32'd1) : req_rs1;
  assign abs_b = (sgn_in & req_rs2[31]) ? (~req_rs2 + 32'd1) : req_rs2;

  // One restoring step: shift in next dividend bit, trial subtract
  assign sh   = {rem, quo[31]};
  assign diff = sh - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)
              state_nx = !is_div ? MUL_WAIT : (fast ? DONE : DIV_RUN);
      MUL_WAIT: if (cnt == 6'(MULT_LAT)) state_nx = DONE;
      DIV_RUN:  if (cnt == 6'd31) state_nx = DIV_FIX;
      DIV_FIX:  state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt        <= 6'd0;
      f3         <= 3'd0;
      rd         <= 5'd0;
      quo        <= 32'd0;
      rem        <= 32'd0;
      dvs        <= 32'd0;
      res        <= 32'd0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      mult_start <= 1'b0;
      mult_type  <= 2'd0;
      mult_a     <= 32'd0;
      mult_b     <= 32'd0;
    end else begin
      mult_start <= 1'b0;
      if (flush) begin
        cnt <= 6'd0;
      end else begin
        unique case (state)
          IDLE: if (accept) begin
            f3  <= req_funct3;
            rd  <= req_rd_addr;
            cnt <= 6'd0;
            if (!is_div) begin
              mult_start <= 1'b1;
              mult_type  <= req_funct3[1:0];
              mult_a     <= req_rs1;
              mult_b     <= req_rs2;
            end else begin
              res   <= fast_res;
              quo   <= abs_a;
              rem   <= 32'd0;
              dvs   <= abs_b;
              neg_q <= sgn_in & (req_rs1[31] ^ req_rs2[31]);
              neg_r <= sgn_in & req_rs1[31];
            end
          end
          MUL_WAIT: begin
            cnt <= cnt + 6'd1;
            if (cnt == 6'(MULT_LAT)) res <= mult_result;
          end
          DIV_RUN: begin
            cnt <= cnt + 6'd1;
            quo <= {quo[30:0], ~diff[32]};
            rem <= diff[32] ? sh[31:0] : diff[31:0];
          end
          DIV_FIX: begin
            cnt <= 6'd0;
            if (f3[1]) res <= neg_r ? (~rem + 32'd1) : rem;
            else       res <= neg_q ? (~quo + 32'd1) : quo;
          end
          DONE:    cnt <= 6'd0;
          default: cnt <= 6'd0;
        endcase
      end
    end
  end

  assign busy  = (state != IDLE);
  assign stall = rst & (((state == IDLE) & req_valid & ~flush)
               | (state == MUL_WAIT) | (state == DIV_RUN)
               | (state == DIV_FIX));

  assign wb_we   = (state == DONE) & (rd != 5'd0) & ~flush & rst;
  assign wb_addr = (state == DONE) ? rd : 5'd0;
  assign wb_data = wb_we ? res : 32'd0;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: phase-counting reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_muldiv_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_rd_addr;
  logic        flush;
  logic        stall, busy, mult_start, wb_we;
  logic [1:0]  mult_type;
  logic [31:0] mult_a, mult_b, mult_result, wb_data;
  logic [4:0]  wb_addr;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit chk_en = 0;

  muldiv_ctrl #(.MULT_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid),
    .req_funct3(req_funct3), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rd_addr(req_rd_addr), .flush(flush), .stall(stall),
    .busy(busy), .mult_start(mult_start), .mult_type(mult_type),
    .mult_a(mult_a), .mult_b(mult_b), .mult_result(mult_result),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sbu;
    logic [63:0] p;
    int ia, ib;
    bit ov;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    sbu = {32'd0, b};
    ia = a;
    ib = b;
    ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = 64'd0;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * sbu; return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ov) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ov) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f,
      input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return LAT + 2;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Behavioural shared multiplier: result valid LAT cycles after start
  logic [31:0] mpend;
  int          mleft = 0;
  bit          marmed = 0;
  always @(posedge clk) begin
    if (mult_start) begin
      mpend  <= ref_res({1'b0, mult_type}, mult_a, mult_b);
      mleft  <= LAT - 1;
      marmed <= 1;
    end else if (marmed && mleft > 0) mleft <= mleft - 1;
    else if (marmed) marmed <= 0;
  end
  assign mult_result = (marmed && mleft == 0) ? mpend : 32'hDEAD_BEEF;

  // Reference model: an op is either absent or at phase 1..lat
  bit          m_act = 0;
  int          m_ph, m_lat;
  logic [31:0] m_res, m_a, m_b;
  logic [4:0]  m_rd;
  logic [1:0]  m_t;
  bit          m_mul;
  always @(posedge clk) begin
    if (!rst) m_act <= 0;
    else if (!m_act) begin
      if (req_valid && !flush) begin
        m_act <= 1;
        m_ph  <= 1;
        m_lat <= lat_of(req_funct3, req_rs1, req_rs2);
        m_res <= ref_res(req_funct3, req_rs1, req_rs2);
        m_rd  <= req_rd_addr;
        m_mul <= !req_funct3[2];
        m_a   <= req_rs1;
        m_b   <= req_rs2;
        m_t   <= req_funct3[1:0];
      end
    end else if (flush || m_ph == m_lat) m_act <= 0;
    else m_ph <= m_ph + 1;
  end

  logic [31:0] last_wb;
  int last_wb_cyc = 0;
  int wb_cnt = 0;
  int ms_cnt = 0;

  always @(negedge clk) begin
    bit e_stall, e_we, e_ms;
    logic [31:0] e_data;
    if (wb_we) begin
      last_wb = wb_data;
      last_wb_cyc = cyc;
      wb_cnt++;
    end
    if (mult_start) ms_cnt++;
    if (chk_en) begin
      e_stall = rst && (m_act ? (m_ph < m_lat) : (req_valid && !flush));
      e_we = m_act && m_ph == m_lat && rst && !flush && m_rd != 0;
      e_data = e_we ? m_res : 32'd0;
      e_ms = m_act && m_mul && m_ph == 1;
      check("ctl", {28'd0, stall, busy, wb_we, mult_start},
            {28'd0, e_stall, m_act, e_we, e_ms});
      check("wb_data", wb_data, e_data);
      if (e_we) check("wb_addr", {27'd0, wb_addr}, {27'd0, m_rd});
      if (m_act && m_mul && m_ph < m_lat) begin
        check("mult_a", mult_a, m_a);
        check("mult_b", mult_b, m_b);
        check("mult_type", {30'd0, mult_type}, {30'd0, m_t});
      end
    end
  end

  task automatic present(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    req_valid   = 1'b1;
    req_funct3  = f;
    req_rs1     = a;
    req_rs2     = b;
    req_rd_addr = rd;
  endtask

  // Holds req_valid through DONE so re-acceptance there is exercised
  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        output int c0);
    int l;
    @(posedge clk); #1;
    present(f, a, b, rd);
    c0 = cyc;
    l = lat_of(f, a, b);
    repeat (l + 1) @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic op_lit(input string name, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    int c0;
    int n0;
    n0 = wb_cnt;
    run_op(f, a, b, 5'd9, c0);
    check({name, "_cnt"}, 32'(wb_cnt - n0), 32'd1);
    check({name, "_val"}, last_wb, exp);
    check({name, "_lat"}, 32'(last_wb_cyc - c0), 32'(exp_lat));
  endtask

  initial begin
    int c0, n0, m0;
    logic [2:0] f;
    logic [31:0] a, b;
    rst = 1'b0; req_valid = 1'b0; flush = 1'b0;
    req_funct3 = 3'd0; req_rs1 = 32'd0; req_rs2 = 32'd0;
    req_rd_addr = 5'd0;
    @(posedge clk); #1 chk_en = 1;
    req_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", {21'd0, stall, busy, mult_start, mult_type,
          wb_we, wb_addr}, 32'd0);
    req_valid = 1'b0;
    rst = 1'b1;

    m0 = ms_cnt;
    n0 = wb_cnt;
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, c0);
    check("mul_val", last_wb, 32'hFFFF_FFEB);
    check("mul_lat", 32'(last_wb_cyc - c0), 32'd4);
    check("mul_cnt", 32'(wb_cnt - n0), 32'd1);
    check("mul_start_cnt", 32'(ms_cnt - m0), 32'd1);

    op_lit("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    op_lit("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    op_lit("divu_z", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    op_lit("remu_z", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    op_lit("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, 1);
    op_lit("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    op_lit("divu_big", 3'd5, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 34);

    // Flush a divide mid-run, then start MULHU right away
    n0 = wb_cnt;
    @(posedge clk); #1;
    present(3'd4, 32'd1000, 32'd7, 5'd4);
    c0 = cyc;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_nowb", 32'(wb_cnt - n0), 32'd0);
    present(3'd3, 32'hFFFF_FFFF, 32'd2, 5'd6);
    c0 = cyc;
    repeat (LAT + 3) @(posedge clk);
    #1 req_valid = 1'b0;
    check("mulhu_val", last_wb, 32'd1);
    check("mulhu_lat", 32'(last_wb_cyc - c0), 32'(LAT + 2));

    // A request presented together with flush is not taken
    @(posedge clk); #1;
    present(3'd5, 32'd9, 32'd3, 5'd2);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
    check("flush_req_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a DIVU
    n0 = wb_cnt;
    @(posedge clk); #1;
    present(3'd5, 32'd50, 32'd3, 5'd7);
    repeat (20) @(posedge clk);
    #1 rst = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    check("mrst_ctl", {21'd0, stall, busy, mult_start, mult_type,
          wb_we, wb_addr}, 32'd0);
    check("mrst_a", mult_a, 32'd0);
    check("mrst_b", mult_b, 32'd0);
    check("mrst_data", wb_data, 32'd0);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    check("mrst_nowb", 32'(wb_cnt - n0), 32'd0);

    // rd = 0 keeps the timing but never writes
    n0 = wb_cnt;
    run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, c0);
    run_op(3'd6, 32'd77, 32'd5, 5'd0, c0);
    check("rd0_nowb", 32'(wb_cnt - n0), 32'd0);

    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = 32'($urandom_range(200)); b = 32'($urandom_range(9)); end
        3: b = 32'($urandom_range(15)) | 32'h8000_0000;
        default: ;
      endcase
      run_op(f, a, b, 5'($urandom_range(31)), c0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
